// File: rtl/dmem_axi_pkg.sv
// Shared definitions for the data-memory AXI4-Lite master: FSM state
// encodings, AXI response codes, CPU access-size codes and the alignment
// predicate used when DMEM_LSU_MISALIGN_CHECK_EN is defined.
package dmem_axi_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Size code 2'b11 is not listed; everything outside byte/half is a word.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } byte_size_e;

    // True when the access is not naturally aligned for its size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            default:   bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for a 32-bit data bus: store data
// replication with write-strobe generation, and load lane extraction with
// sign/zero extension. Lane choice uses only the naturally aligned address
// bits (half uses addr[1], word ignores both).
module lsu_lane_align
    import dmem_axi_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_lanes,
    output logic [3:0]  wstrb,
    output logic [31:0] rdata_ext
);

    // Store side: replicate the right-aligned value onto every lane.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        wdata_lanes = wdata;
        wstrb       = 4'b1111;
        case (size)
            SIZE_BYTE: begin
                wdata_lanes = {4{wdata[7:0]}};
                wstrb       = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata_lanes = {2{wdata[15:0]}};
                wstrb       = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane and extend it to 32 bits.
    always_comb begin
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = rdata;
        case (size)
            SIZE_BYTE: rdata_ext = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SIZE_HALF: rdata_ext = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_axi_master.sv
// AXI4-Lite master for the CPU MEM stage: one single-beat transaction per
// load/store request, pipeline stall while outstanding, one-cycle done pulse.
// Optional build macro: DMEM_LSU_MISALIGN_CHECK_EN rejects misaligned
// half/word accesses locally (no AXI traffic, cpu_err=1, cpu_rdata=0).
module dmem_axi_master
    import dmem_axi_pkg::*;
#(
    parameter logic [2:0] PROT_VAL = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_byte_size,
    input  logic        cpu_sign_ext,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    output logic [31:0] M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    logic [2:0]  state;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic        misalign;
    logic        in_idle;
    logic [1:0]  lane_addr;
    logic [1:0]  lane_size;
    logic        lane_sign;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_rdata;

    assign in_idle = (state == ST_IDLE);
    assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID & M_AXI_WREADY;

`ifdef DMEM_LSU_MISALIGN_CHECK_EN
    assign misalign = is_misaligned(cpu_byte_size, cpu_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // The aligner sees the live request in IDLE (store lanes are registered
    // on accept) and the latched request afterwards (load extract).
    assign lane_addr = in_idle ? cpu_addr[1:0] : addr_lo_q;
    assign lane_size = in_idle ? cpu_byte_size : size_q;
    assign lane_sign = in_idle ? cpu_sign_ext  : sign_q;

    lsu_lane_align u_align (
        .addr_lo     (lane_addr),
        .size        (lane_size),
        .sign_ext    (lane_sign),
        .wdata       (cpu_wdata),
        .rdata       (M_AXI_RDATA),
        .wdata_lanes (lane_wdata),
        .wstrb       (lane_wstrb),
        .rdata_ext   (lane_rdata)
    );

    assign M_AXI_AWPROT = PROT_VAL;
    assign M_AXI_ARPROT = PROT_VAL;
    assign cpu_done     = (state == ST_DONE);
    assign cpu_stall    = cpu_req & ~cpu_done;

    // Transaction FSM with registered AXI valids/readies and CPU results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr_lo_q     <= 2'b00;
            size_q        <= 2'b00;
            sign_q        <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= 32'h0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= 32'h0;
            M_AXI_WSTRB   <= 4'h0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= 32'h0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            cpu_rdata     <= 32'h0;
            cpu_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        addr_lo_q <= cpu_addr[1:0];
                        size_q    <= cpu_byte_size;
                        sign_q    <= cpu_sign_ext;
                        if (misalign) begin
                            cpu_err   <= 1'b1;
                            cpu_rdata <= 32'h0;
                            state     <= ST_DONE;
                        end else if (cpu_we) begin
                            M_AXI_AWADDR  <= cpu_addr;
                            M_AXI_WDATA   <= lane_wdata;
                            M_AXI_WSTRB   <= lane_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WR_REQ;
                        end else begin
                            M_AXI_ARADDR  <= cpu_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        cpu_err      <= (M_AXI_BRESP != RESP_OKAY);
                        state        <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        cpu_rdata    <= lane_rdata;
                        cpu_err      <= (M_AXI_RRESP != RESP_OKAY);
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
